uart_tx_shifter: RTL

Serial transmit engine for the UART Tx path. It sits directly downstream of the Tx control/status register and consumes that register's enable, stop-bit, parity and "data pending" outputs together with the data byte. It then drives a standard asynchronous frame onto the `tx` line. When the frame completes it returns a one-cycle `done` pulse, which upstream logic uses to clear the pending flag.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_tx_shifter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int UART_BITCNT_W  = 3;
    localparam int UART_BAUDCNT_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Even parity is the XOR of the byte; odd parity is its complement.
    function automatic logic parity_bit(input logic [UART_DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time down-counter. tick is high in the last cycle of each bit; a load
// restarts the count at CLKS_PER_BIT-1 so that every bit lasts CLKS_PER_BIT cycles.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tick
);

    localparam logic [UART_BAUDCNT_W-1:0] LOAD_VAL = UART_BAUDCNT_W'(CLKS_PER_BIT - 1);

    logic [UART_BAUDCNT_W-1:0] cnt;

    // Count down to zero and hold there until the next load.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - UART_BAUDCNT_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_shifter.sv
// UART serial transmit engine: start bit, 8 data bits LSB first, optional
// parity bit, then one or two stop bits.
// Build option: define UART_TX_PARITY_EN to include the parity bit.
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tx_en_i,
    input  logic                   two_stop_i,
    input  logic                   odd_parity_i,
    input  logic                   start_i,
    input  logic [UART_DATA_W-1:0] data_i,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   done_o
);

    tx_state_e                state, state_next;
    logic [UART_BITCNT_W-1:0] bit_idx, bit_idx_next;
    logic                     stop_idx, stop_idx_next;
    logic [UART_DATA_W-1:0]   data_q;
    logic                     two_stop_q;
    logic                     tick;
    logic                     load;
    logic                     accept;
    logic                     frame_end;
    logic                     tx_next;

`ifdef UART_TX_PARITY_EN
    logic odd_q;
`else
    // Parity sense has no effect in this build.
    logic unused_odd_parity;
    assign unused_odd_parity = odd_parity_i;
`endif

    // done_o blocks acceptance so a pending flag that upstream is still
    // clearing cannot re-send the same byte; with start_i held high the next
    // start bit follows one extra idle cycle after the done cycle.
    assign accept    = (state == IDLE) && tx_en_i && start_i && !done_o;
    assign load      = accept || (tick && (state != IDLE));
    assign frame_end = (state == STOP) && tick && (stop_idx || !two_stop_q);
    assign busy_o    = (state != IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .tick (tick)
    );

    // State register with data-bit and stop-bit counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            state    <= state_next;
            bit_idx  <= bit_idx_next;
            stop_idx <= stop_idx_next;
        end
    end

    // Capture the frame contents at acceptance so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= '0;
            two_stop_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            odd_q      <= 1'b0;
`endif
        end else if (accept) begin
            data_q     <= data_i;
            two_stop_q <= two_stop_i;
`ifdef UART_TX_PARITY_EN
            odd_q      <= odd_parity_i;
`endif
        end
    end

    // Next-state logic: advance one frame field per bit tick.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_next    = state;
        bit_idx_next  = bit_idx;
        stop_idx_next = stop_idx;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next    = START;
                    bit_idx_next  = '0;
                    stop_idx_next = 1'b0;
                end
            end
            START: begin
                if (tick) state_next = DATA;
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == UART_BITCNT_W'(UART_DATA_W - 1)) begin
                        bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + UART_BITCNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) state_next = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    if (two_stop_q && !stop_idx) begin
                        stop_idx_next = 1'b1;
                    end else begin
                        state_next    = IDLE;
                        stop_idx_next = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: line level for the bit that starts at the coming edge.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:  tx_next = 1'b0;
            DATA:   tx_next = data_q[bit_idx_next];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_next = parity_bit(data_q, odd_q);
`endif
            default: tx_next = 1'b1;
        endcase
    end

    // Registered line and done pulse keep tx_o glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_o   <= 1'b1;
            done_o <= 1'b0;
        end else begin
            tx_o   <= tx_next;
            done_o <= frame_end;
        end
    end

endmodule
